// File: rtl/bus_debug_master.sv
// bus_debug_master: UART byte-command initiator for the OUTBUS/INBUS peripheral bus.
// Define BUSDBG_WRITE_ACK_EN to return '.' after each completed write.
module bus_debug_master #(
  parameter int          READ_LATENCY   = 1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic [7:0] outbus_addr,
  output logic [7:0] outbus_data,
  output logic       outbus_we,
  output logic [7:0] inbus_addr,
  input  logic [7:0] inbus_data,
  output logic       inbus_re,
  output logic       busy,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, REQ, BUS_WR, BUS_RD, RD_WAIT, SEND} state_t;
  state_t      state_q, state_d;
  logic        wr_q, wr_d, overrun_q, overrun_d, tx_valid_q, tx_valid_d;
  logic        bus_req_q, bus_req_d, we_q, we_d, re_q, re_d, busy_q, busy_d;
  logic [7:0]  addr_q, addr_d, data_q, data_d, tx_data_q, tx_data_d;
  logic [7:0]  oaddr_q, oaddr_d, odata_q, odata_d, iaddr_q, iaddr_d;
  logic [15:0] tout_q, tout_d;
  logic [1:0]  lat_q, lat_d;
  logic        is_cmd;
  assign is_cmd = rx_data == 8'h57 || rx_data == 8'h52;
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tout_d    = tout_q;
    lat_d     = lat_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (rx_valid) begin
        wr_d      = rx_data == 8'h57;
        tout_d    = '0;
        state_d   = is_cmd ? GET_ADDR : SEND;
        tx_data_d = is_cmd ? 8'h00 : 8'h3F;
      end
      GET_ADDR, GET_DATA: if (rx_valid) begin
        tout_d  = '0;
        addr_d  = state_q == GET_ADDR ? rx_data : addr_q;
        data_d  = state_q == GET_DATA ? rx_data : data_q;
        state_d = (state_q == GET_ADDR && wr_q) ? GET_DATA : REQ;
      end else if (tout_q == TIMEOUT_CYCLES - 16'd1) begin
        state_d = IDLE;
      end else begin
        tout_d = tout_q + 16'd1;
      end
      REQ: state_d = bus_grant ? (wr_q ? BUS_WR : BUS_RD) : REQ;
      BUS_WR: begin
`ifdef BUSDBG_WRITE_ACK_EN
        state_d   = SEND;
        tx_data_d = 8'h2E;
`else
        state_d = IDLE;
`endif
      end
      BUS_RD: begin
        state_d = RD_WAIT;
        lat_d   = 2'd1;
      end
      RD_WAIT: if (lat_q == 2'(READ_LATENCY)) begin
        state_d   = SEND;
        tx_data_d = inbus_data;
      end else begin
        lat_d = lat_q + 2'd1;
      end
      SEND: if (tx_ready) begin
        state_d   = IDLE;
        tx_data_d = 8'h00;
      end
      default: state_d = IDLE;
    endcase
    overrun_d  = overrun_q | (rx_valid && state_q inside {REQ, BUS_WR, BUS_RD, RD_WAIT, SEND});
    // outputs are decoded from the next state so they are flops yet track the state exactly
    tx_valid_d = state_d == SEND;
    busy_d     = state_d != IDLE;
    bus_req_d  = state_d inside {REQ, BUS_WR, BUS_RD, RD_WAIT};
    we_d       = state_d == BUS_WR;
    re_d       = state_d == BUS_RD;
    oaddr_d    = we_d ? addr_d : 8'h00;
    odata_d    = we_d ? data_d : 8'h00;
    iaddr_d    = state_d inside {BUS_RD, RD_WAIT} ? addr_d : 8'h00;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      tout_q     <= '0;
      lat_q      <= '0;
      tx_data_q  <= '0;
      overrun_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      oaddr_q    <= '0;
      odata_q    <= '0;
      iaddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tout_q     <= tout_d;
      lat_q      <= lat_d;
      tx_data_q  <= tx_data_d;
      overrun_q  <= overrun_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      bus_req_q  <= bus_req_d;
      we_q       <= we_d;
      re_q       <= re_d;
      oaddr_q    <= oaddr_d;
      odata_q    <= odata_d;
      iaddr_q    <= iaddr_d;
    end
  end
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign bus_req     = bus_req_q;
  assign outbus_addr = oaddr_q;
  assign outbus_data = odata_q;
  assign outbus_we   = we_q;
  assign inbus_addr  = iaddr_q;
  assign inbus_re    = re_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_bus_debug_master.sv
// tb_bus_debug_master: table-driven bench with tx/write scoreboards for bus_debug_master.
module tb_bus_debug_master;
`ifdef BUSDBG_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic [7:0] rx_data = 0, inbus_data = 0;
  logic rx_valid = 0, tx_ready = 1, bus_grant = 0;
  logic [7:0] tx_data, outbus_addr, outbus_data, inbus_addr;
  logic tx_valid, bus_req, outbus_we, inbus_re, busy, overrun;
  logic [37:0] outs;
  assign outs = {tx_data, tx_valid, bus_req, outbus_addr, outbus_data, outbus_we, inbus_addr, inbus_re, busy, overrun};

  bus_debug_master #(.READ_LATENCY(1), .TIMEOUT_CYCLES(16'd16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .outbus_addr(outbus_addr), .outbus_data(outbus_data), .outbus_we(outbus_we),
    .inbus_addr(inbus_addr), .inbus_data(inbus_data), .inbus_re(inbus_re),
    .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op, a, d;
    bit bus;
    int gdly;
    bit has_tx;
    logic [7:0] tx;
    bit wr;
  } vec_t;
  vec_t vecs[8];
  int n_cmp = 0, n_err = 0, req_cycles = 0, r0, n;
  logic [7:0] mem[256];
  logic [7:0] txq[$];
  logic [15:0] wq[$];
  logic rd_pend;
  logic [7:0] rd_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_data = b; rx_valid = 1;
    @(posedge clk); #1 rx_valid = 0; rx_data = 0;
  endtask

  task automatic wait_req();
    int k = 0;
    @(negedge clk);
    while (!bus_req && k < 100) begin @(negedge clk); k++; end
    chk("bus_req_rise", bus_req, 1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge clk);
    while (busy && k < 100) begin @(negedge clk); k++; end
    chk(nm, busy, 0);
  endtask

  task automatic do_grant(input int gdly, input bit wr, input logic [7:0] a);
    repeat (gdly + 1) @(posedge clk);
    #1 bus_grant = 1;
    @(negedge clk); chk("strobe_before_grant_edge", {outbus_we, inbus_re}, 2'b00);
    @(negedge clk); chk("strobe_after_grant", {outbus_we, inbus_re}, wr ? 2'b10 : 2'b01);
    if (!wr) chk("re_addr", inbus_addr, a);
    @(posedge clk); #1 bus_grant = 0;
    @(negedge clk); chk("strobe_single_cycle", {outbus_we, inbus_re}, 2'b00);
  endtask

  // responder: registers the addressed byte one cycle after inbus_re
  initial forever begin
    @(negedge clk); rd_pend = inbus_re; rd_a = inbus_addr;
    @(posedge clk); #1 inbus_data = rd_pend ? mem[rd_a] : 8'h00;
  end

  initial forever begin
    @(negedge clk);
    if (bus_req) req_cycles++;
    if (tx_valid && tx_ready) begin
      if (txq.size() == 0) chk("tx_unexpected", tx_valid, 0);
      else chk("tx_data", tx_data, txq.pop_front());
    end
    if (outbus_we) begin
      if (wq.size() == 0) chk("wr_unexpected", outbus_we, 0);
      else chk("wr_addr_data", {outbus_addr, outbus_data}, wq.pop_front());
      mem[outbus_addr] = outbus_data;
    end
    if (!outbus_we) chk("wr_bus_zero", {outbus_addr, outbus_data}, 0);
    if (!bus_req) chk("rd_bus_zero", {inbus_re, inbus_addr}, 0);
  end

  initial begin
    #500000 $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h02; mem[8'h30] = 8'h5C; mem[8'hFF] = 8'hC3;
    vecs[0] = '{8'h57, 8'h56, 8'hA5, 1'b1, 3, ACK,  8'h2E, 1'b1};
    vecs[1] = '{8'h52, 8'h00, 8'h00, 1'b1, 0, 1'b1, 8'h02, 1'b0};
    vecs[2] = '{8'h41, 8'h00, 8'h00, 1'b0, 0, 1'b1, 8'h3F, 1'b0};
    vecs[3] = '{8'h52, 8'h30, 8'h00, 1'b1, 2, 1'b1, 8'h5C, 1'b0};
    vecs[4] = '{8'h57, 8'h30, 8'h77, 1'b1, 1, ACK,  8'h2E, 1'b1};
    vecs[5] = '{8'h52, 8'h30, 8'h00, 1'b1, 0, 1'b1, 8'h77, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b1, 8'h3F, 1'b0};
    vecs[7] = '{8'h52, 8'hFF, 8'h00, 1'b1, 5, 1'b1, 8'hC3, 1'b0};
    #1 reset = 0;
    #1 chk("reset_outputs", outs, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      r0 = req_cycles;
      if (vecs[i].has_tx) txq.push_back(vecs[i].tx);
      if (vecs[i].wr) wq.push_back({vecs[i].a, vecs[i].d});
      send_byte(vecs[i].op);
      if (vecs[i].op == 8'h57 || vecs[i].op == 8'h52) send_byte(vecs[i].a);
      if (vecs[i].op == 8'h57) send_byte(vecs[i].d);
      if (vecs[i].bus) begin
        wait_req();
        do_grant(vecs[i].gdly, vecs[i].wr, vecs[i].a);
      end
      wait_idle("vec_idle");
      chk("req_low_after", bus_req, 0);
      if (!vecs[i].bus) chk("no_req_for_bad_op", req_cycles, r0);
    end
    chk("overrun_clear", overrun, 0);
    chk("tx_queue_drained", txq.size(), 0);
    // timeout: 16 idle cycles in GET_DATA abandon the command
    send_byte(8'h57); send_byte(8'h10);
    repeat (15) @(posedge clk);
    @(negedge clk); chk("timeout_not_yet", busy, 1);
    @(negedge clk); chk("timeout_idle", busy, 0);
    chk("timeout_no_req", bus_req, 0);
    // a byte in the expiry cycle wins over the timeout
    wq.push_back(16'h2066);
    if (ACK) txq.push_back(8'h2E);
    send_byte(8'h57); send_byte(8'h20);
    repeat (14) @(posedge clk);
    send_byte(8'h66);
    wait_req(); do_grant(0, 1, 8'h20); wait_idle("boundary_idle");
    txq.push_back(8'h77);
    send_byte(8'h52); send_byte(8'h30);
    wait_req(); do_grant(1, 0, 8'h30); wait_idle("read_after_timeout");
    // overrun and tx backpressure
    txq.push_back(8'h66);
    tx_ready = 0;
    send_byte(8'h52); send_byte(8'h20);
    wait_req();
    repeat (20) @(posedge clk);
    send_byte(8'h99);
    repeat (28) @(posedge clk);
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    chk("req_held_no_grant", bus_req, 1);
    do_grant(0, 0, 8'h20);
    n = 0;
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("tx_stable", {tx_valid, tx_data}, {1'b1, 8'h66});
    end
    @(posedge clk); #1 tx_ready = 1;
    wait_idle("backpressure_idle");
    chk("overrun_sticky", overrun, 1);
    // asynchronous reset during RD_WAIT
    send_byte(8'h52); send_byte(8'h30);
    wait_req();
    @(posedge clk); #1 bus_grant = 1;
    @(negedge clk);
    @(negedge clk); chk("rd_strobe", inbus_re, 1);
    @(posedge clk); #2;
    chk("rd_wait_state", {inbus_re, inbus_addr, bus_req}, {1'b0, 8'h30, 1'b1});
    reset = 0;
    #1 chk("async_reset_outputs", outs, 0);
    bus_grant = 0;
    @(negedge clk); reset = 1;
    txq.push_back(8'h77);
    send_byte(8'h52); send_byte(8'h30);
    wait_req(); do_grant(0, 0, 8'h30); wait_idle("read_after_reset");
    chk("overrun_after_reset", overrun, 0);
    chk("final_tx_queue", txq.size(), 0);
    chk("final_wr_queue", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bus_debug_master.md
# bus_debug_master

Byte-command-driven initiator for the processor's OUTBUS/INBUS peripheral bus, the initiator-side counterpart to the existing bus responders (cycle counter, processor version, rs232 port). Bytes arrive from a UART receive byte stream and are parsed into single write or read transactions. The block requests the bus, performs the access once granted, and returns a response byte on a transmit byte stream. It sits between an rs232 byte interface and the bus arbiter/mux in the top level, giving host-side peek/poke access to every device address.

## Interface
- READ_LATENCY, 1: cycles from the inbus_re cycle to the inbus_data sample (1..3).
- TIMEOUT_CYCLES, 16'hFFFF: maximum idle cycles between bytes of one command.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte pending; held until accepted.
- tx_ready  in  1  sink accepts when tx_valid && tx_ready.
- bus_req  out  1  requests bus ownership.
- bus_grant  in  1  bus owned; processor bus outputs are muxed away.
- outbus_addr  out  8  write address.
- outbus_data  out  8  write data.
- outbus_we  out  1  one-cycle write strobe.
- inbus_addr  out  8  read address.
- inbus_data  in  8  wired-OR read data from responders.
- inbus_re  out  1  one-cycle read strobe.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky flag: a byte was dropped; cleared only by reset.

## Operation
- Commands: 0x57 'W', addr, data -> write; 0x52 'R', addr -> read; any other first byte -> respond 0x3F '?' and return to IDLE.
- States: IDLE, GET_ADDR, GET_DATA, REQ, BUS_WR, BUS_RD, RD_WAIT, SEND.
- IDLE: 'W' or 'R' -> GET_ADDR, latching the opcode; any other byte -> SEND with 0x3F.
- GET_ADDR: byte -> addr. On 'W' go to GET_DATA; on 'R' go to REQ.
- GET_DATA: byte -> data, then go to REQ.
- REQ: bus_req=1. Wait for bus_grant indefinitely (no timeout). On grant, go to BUS_WR or BUS_RD.
- BUS_WR: outbus_we=1 with addr/data for exactly one cycle, then SEND with ack, or IDLE (see Configuration).
- BUS_RD: inbus_re=1 with inbus_addr for one cycle, then RD_WAIT. Sample inbus_data READ_LATENCY cycles after the BUS_RD cycle, then go to SEND with the sampled byte.
- SEND: tx_valid=1 with tx_data stable until tx_ready. On acceptance go to IDLE.
- Bytes arriving while in REQ..SEND are dropped and set overrun.
- The timeout counter clears on every accepted byte. In GET_ADDR/GET_DATA, TIMEOUT_CYCLES idle cycles -> IDLE, with no bus access and no response.
- Bus outputs (addr, data, we, re) are 0 whenever the block is not in BUS_WR/BUS_RD/RD_WAIT, so an ungated OR into the bus is safe.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset is asynchronous and aborts any phase; bus_req and all strobes drop immediately.
- Grant is sampled at edge N. The strobe (we or re) is high in cycle N+1 only.
- Write: bus_req falls after the strobe cycle.
- Read: inbus_addr is held through the sample cycle. bus_req falls the cycle after the sample.
- Grant deasserted mid-transaction: the block ignores it and completes the access (the arbiter must not revoke).
- A byte arriving in the same cycle as the timeout expiry is accepted and the timeout is ignored.
- tx_valid rises the cycle after entering SEND. Zero-wait acceptance means SEND lasts one cycle.

## Configuration
- BUSDBG_WRITE_ACK_EN defined: every completed write returns byte 0x2E '.' through SEND.
- BUSDBG_WRITE_ACK_EN undefined: a write returns to IDLE directly after BUS_WR, with no tx activity. Read and error responses are unchanged.

## Test plan
- Write: rx 0x57,0x56,0xA5; grant 3 cycles after bus_req -> one-cycle outbus_we with addr 0x56, data 0xA5 exactly one cycle after grant; tx 0x2E (macro defined).
- Read: rx 0x52,0x00; responder returns 0x02 with READ_LATENCY=1 -> one inbus_re cycle with addr 0x00; tx_data 0x02; bus_req low afterwards.
- Unknown opcode 0x41 -> tx 0x3F; no bus_req ever asserted.
- Timeout: TIMEOUT_CYCLES=16; rx 0x57,0x10, then silence for 16 cycles -> IDLE, no write. Follow with rx 0x52,0x30 -> normal read.
- Overrun/backpressure: hold bus_grant low for 50 cycles while sending byte 0x99, then tx_ready low for 10 cycles -> overrun=1, tx_data stable throughout, transaction still completes.
- Reset mid-read: assert reset during RD_WAIT -> all outputs 0 asynchronously. After release, rx 0x52,0x30 -> correct response. With the macro undefined, a write produces no tx_valid.
